mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing front-end for the 8x8 NAND-latch `Memory_unit` bitcell array. It accepts word read/write requests from a host over a valid/ready handshake and converts each into a glitch-safe setup/strobe/hold pulse on the array's `op`/`select`/`address`/`in_bus` pins. It registers read data from `out_bus`, and can optionally sweep the whole array to zero after power-up, when latch contents are undefined.

## Interface
- `ADDR_W`, default 3: array address width; the array has 2^ADDR_W words.
- `DATA_W`, default 8: word width.

Ports:
- `clk` — in, 1: single clock. All state changes on the rising edge.
- `rst` — in, 1: reset, synchronous, active-high.
- `req_valid` — in, 1: host request present.
- `req_ready` — out, 1: high only in IDLE and not in reset; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write` — in, 1: 1 = write, 0 = read.
- `req_clear` — in, 1: clear-all request, qualified by `req_valid`. Ignored when `MEM_CLEAR_EN` is undefined.
- `req_addr` — in, ADDR_W: target word.
- `req_wdata` — in, DATA_W: write data.
- `rsp_valid` — out, 1: one-cycle completion pulse.
- `rsp_rdata` — out, DATA_W: read data, held until the next read completes.
- `busy` — out, 1: high in any state other than IDLE.
- `mem_op` — out, 1: drives `Memory_unit.op` (1 = write, 0 = read).
- `mem_select` — out, 1: drives `Memory_unit.select`.
- `mem_address` — out, ADDR_W: drives `Memory_unit.address`.
- `mem_in_bus` — out, DATA_W: drives `Memory_unit.in_bus`.
- `mem_out_bus` — in, DATA_W: from `Memory_unit.out_bus`.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- All `mem_*` outputs are registered. No combinational path from the host to `mem_select`.
- **IDLE:** `mem_select`=0. On accept, latch `req_write`, `req_addr` and `req_wdata` into `mem_op`, `mem_address` and `mem_in_bus`, then go to SETUP.
- **SETUP:** `mem_select`=0, with op/address/data stable. Go to STROBE.
- **STROBE:** `mem_select`=1. For a read, `rsp_rdata` <= `mem_out_bus` on the edge leaving STROBE. Go to HOLD.
- **HOLD:** `mem_select`=0, with op/address/data still stable, so no latch is open while its inputs change. `rsp_valid`=1 when the op is complete. Next state is IDLE.
- For writes, `rsp_valid` pulses and `rsp_rdata` is unchanged.
- Host inputs are ignored while `busy`.
- Precedence when `req_valid` is high: `req_clear` (if compiled in), then `req_write`, then read.
- The address is used as-is. No wrap or bounds logic is needed, because every ADDR_W value is a valid word.

## Timing
- Reset values:
  - `mem_select`=0, `mem_op`=0, `mem_address`=0, `mem_in_bus`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
  - `req_ready`=0 while `rst` is high, and 1 on the first cycle after release.
- Single access:
  - Accept at edge E.
  - SETUP during E..E+1, STROBE during E+1..E+2, HOLD during E+2..E+3.
  - `rsp_valid` is high in the HOLD cycle. `req_ready` returns high in the cycle after HOLD.
  - Throughput is one access per 4 cycles. Back-to-back accesses run with no extra idle cycle beyond IDLE.
- Reset mid-operation: at the first edge with `rst`=1, the FSM goes to IDLE, `mem_select` is forced to 0 and no `rsp_valid` is issued. A write interrupted in STROBE leaves that word undefined.
- `mem_out_bus` is sampled only at the STROBE exit edge. It is don't-care at all other times.

## Configuration
- Macro: `MEM_CLEAR_EN`.
- **Defined:** an accepted `req_clear` runs SETUP/STROBE/HOLD once per address, 0 through 2^ADDR_W−1 in order, with `mem_op`=1 and `mem_in_bus`=0.
  - `busy` stays high throughout.
  - `rsp_valid` pulses once, in the final HOLD.
  - Sequence length is 3·2^ADDR_W cycles: 24 cycles at the defaults.
  - Reset mid-sweep aborts the sweep; the remaining words stay undefined.
- **Undefined:** no sweep counter is built, `req_clear` is ignored, and a request with `req_clear`=1 executes as a plain read or write according to `req_write`.

## Test plan
- **Write then read:** write 0x55 to addr 0, then read addr 0.
  - `mem_select` is high exactly 1 cycle per access, and `mem_in_bus`/`mem_address` are stable from SETUP through HOLD.
  - The read returns `rsp_rdata`=0x55 with `rsp_valid` 3 cycles after accept.
- **Second word:** write 0xF0 to addr 4, then read addr 4 and addr 0.
  - Read data is 0xF0 and 0x55 respectively, with no cross-word corruption.
- **Handshake:** hold `req_valid` high with changing addr/data for 3 cycles after accept.
  - `req_ready`=0 during that time and the changes are ignored. The next request is accepted exactly 4 cycles after the first.
- **Reset during STROBE:** assert `rst` on a write to addr 2.
  - Next cycle shows `mem_select`=0, `busy`=0 and `rsp_valid`=0.
  - `req_ready`=1 on the cycle after `rst` is released.
- **Clear sweep (`MEM_CLEAR_EN`):** after writing 0xFF to addr 7, issue `req_clear`.
  - `rsp_valid` arrives 24 cycles after accept, and `mem_address` steps 0→7.
  - Reading any address afterwards returns 0x00.
- **Clear without macro:** build without `MEM_CLEAR_EN` and issue `req_clear`=1, `req_write`=0 to addr 3.
  - Behaves as a normal 4-cycle read.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sequencer for the 8x8 NAND-latch Memory_unit: setup/strobe/hold per access.
// Optional power-up clear sweep is compiled in with MEM_CLEAR_EN.
module mem_access_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_clear,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              mem_op,
   output logic              mem_select,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in_bus,
   input  logic [DATA_W-1:0] mem_out_bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_op;
   logic              r_sel;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rsp;
   logic              w_accept;
   logic              w_last;

`ifdef MEM_CLEAR_EN
   logic              r_clr;

   // a sweep is finished once the top word has been strobed
   assign w_last = !r_clr || (r_addr == {ADDR_W{1'b1}});
`else
   logic              w_unused;

   assign w_unused = req_clear;
   assign w_last   = 1'b1;
`endif

   assign req_ready = (r_state == S_IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign busy      = (r_state != S_IDLE);

   assign rsp_valid   = r_rsp;
   assign rsp_rdata   = r_rdata;
   assign mem_op      = r_op;
   assign mem_select  = r_sel;
   assign mem_address = r_addr;
   assign mem_in_bus  = r_wdata;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state logic; HOLD loops back to SETUP while a sweep is running
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (w_accept) w_next = S_SETUP;
         S_SETUP:  w_next = S_STROBE;
         S_STROBE: w_next = S_HOLD;
         S_HOLD:   w_next = w_last ? S_IDLE : S_SETUP;
         default:  w_next = S_IDLE;
      endcase
   end

   // registered array pins, read capture and completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op    <= 1'b0;
         r_sel   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_rsp   <= 1'b0;
`ifdef MEM_CLEAR_EN
         r_clr   <= 1'b0;
`endif
      end else begin
         r_rsp <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_sel <= 1'b0;
               if (w_accept) begin
`ifdef MEM_CLEAR_EN
                  r_clr <= req_clear;
                  if (req_clear) begin
                     r_op    <= 1'b1;
                     r_addr  <= '0;
                     r_wdata <= '0;
                  end else
`endif
                  begin
                     r_op    <= req_write;
                     r_addr  <= req_addr;
                     r_wdata <= req_wdata;
                  end
               end
            end
            S_SETUP: begin
               r_sel <= 1'b1;
            end
            S_STROBE: begin
               r_sel <= 1'b0;
               r_rsp <= w_last;
               if (!r_op) begin
                  r_rdata <= mem_out_bus;
               end
            end
            S_HOLD: begin
               r_sel <= 1'b0;
               if (!w_last) begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            default: begin
               r_sel <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural latch-array model.
// Build with +define+MEM_CLEAR_EN to exercise the clear sweep.
module tb_mem_access_ctrl;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic       req_clear;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic       mem_op;
   logic       mem_select;
   logic [2:0] mem_address;
   logic [7:0] mem_in_bus;
   logic [7:0] mem_out_bus;

`ifdef MEM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   int         nchk;
   int         nfail;
   logic [7:0] tb_mem [8];
   logic [7:0] ref_mem [8];
   logic [7:0] last_rd;
   logic [7:0] exp_q [$];
   logic [2:0] sel_log [$];
   logic       mem_init;

   mem_access_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_clear   (req_clear),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .busy        (busy),
      .mem_op      (mem_op),
      .mem_select  (mem_select),
      .mem_address (mem_address),
      .mem_in_bus  (mem_in_bus),
      .mem_out_bus (mem_out_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // array model: random power-up contents, latch write while selected
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 8; i++) tb_mem[i] <= 8'($urandom);
      end else if (mem_select && mem_op) begin
         tb_mem[mem_address] <= mem_in_bus;
      end
   end
   assign mem_out_bus = tb_mem[mem_address];

   // log which word is strobed
   always @(negedge clk) begin
      if (mem_select) sel_log.push_back(mem_address);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic w, input logic c,
                        input logic [2:0] a, input logic [7:0] d,
                        output int lat, output int nsel,
                        output bit stable);
      logic [2:0] a0;
      logic [7:0] d0;
      logic       o0;
      int         n;
      @(negedge clk);
      sel_log.delete();
      req_valid = 1'b1;
      req_write = w;
      req_clear = c;
      req_addr  = a;
      req_wdata = d;
      if (c && CLR) begin
         for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
         exp_q.push_back(last_rd);
      end else if (w) begin
         ref_mem[a] = d;
         exp_q.push_back(last_rd);
      end else begin
         exp_q.push_back(ref_mem[a]);
         last_rd = ref_mem[a];
      end
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 3'($urandom);
      req_wdata = 8'($urandom);
      req_write = 1'($urandom);
      req_clear = 1'b0;
      a0 = mem_address;
      d0 = mem_in_bus;
      o0 = mem_op;
      stable = 1'b1;
      nsel = 0;
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         if (mem_in_bus !== d0 || mem_op !== o0) stable = 1'b0;
         if (!(c && CLR) && mem_address !== a0) stable = 1'b0;
         if (mem_select) nsel++;
         @(negedge clk);
         lat++;
      end
      if (mem_in_bus !== d0 || mem_address !== a0 && !(c && CLR))
         stable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_init = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_clear = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      last_rd = 8'h00;
      repeat (3) @(negedge clk);
      nchk++;
      if (req_ready !== 1'b0) begin
         nfail++;
         $display("FAIL reset_ready: got %b want 0", req_ready);
      end
      nchk++;
      if ({mem_select, mem_op, mem_address, mem_in_bus} !== 13'h0) begin
         nfail++;
         $display("FAIL reset_mem: got sel=%b op=%b a=%h d=%h want 0",
                  mem_select, mem_op, mem_address, mem_in_bus);
      end
      nchk++;
      if ({rsp_valid, rsp_rdata, busy} !== 10'h0) begin
         nfail++;
         $display("FAIL reset_rsp: got v=%b rd=%h busy=%b want 0",
                  rsp_valid, rsp_rdata, busy);
      end
      rst = 1'b0;
      mem_init = 1'b0;
      @(negedge clk);
      nchk++;
      if (req_ready !== 1'b1) begin
         nfail++;
         $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic one_access(input string nm, input logic w,
                             input logic [2:0] a, input logic [7:0] d);
      int         lat;
      int         nsel;
      bit         st;
      logic [7:0] e;
      issue(w, 1'b0, a, d, lat, nsel, st);
      nchk++;
      if (lat !== 2) begin
         nfail++;
         $display("FAIL %s_latency: got %0d want 2", nm, lat);
      end
      nchk++;
      if (nsel !== 1 || !st) begin
         nfail++;
         $display("FAIL %s_strobe: got sel_cycles=%0d stable=%0b want 1/1",
                  nm, nsel, st);
      end
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      nchk++;
      if (rsp_rdata !== e) begin
         nfail++;
         $display("FAIL %s_rdata: got %h want %h", nm, rsp_rdata, e);
      end
   endtask

   task automatic test_write_read();
      one_access("wr55_a0", 1'b1, 3'd0, 8'h55);
      one_access("rd_a0", 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_second_word();
      one_access("wrF0_a4", 1'b1, 3'd4, 8'hF0);
      one_access("rd_a4", 1'b0, 3'd4, 8'h00);
      one_access("rd_a0_again", 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_handshake();
      int         n;
      logic [7:0] e;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_clear = 1'b0;
      req_addr  = 3'd1;
      req_wdata = 8'hAA;
      ref_mem[1] = 8'hAA;
      exp_q.push_back(last_rd);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         req_addr  = 3'($urandom);
         req_wdata = 8'($urandom);
         req_write = 1'($urandom);
         nchk++;
         if (req_ready !== 1'b0 || mem_address !== 3'd1 ||
             mem_in_bus !== 8'hAA || mem_op !== 1'b1) begin
            nfail++;
            $display("FAIL hs_busy_%0d: got rdy=%b a=%h d=%h op=%b want 0/1/AA/1",
                     i, req_ready, mem_address, mem_in_bus, mem_op);
         end
         if (i == 2) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            nchk++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e) begin
               nfail++;
               $display("FAIL hs_wr_rsp: got v=%b rd=%h want 1/%h",
                        rsp_valid, rsp_rdata, e);
            end
         end
         @(negedge clk);
      end
      req_write = 1'b0;
      req_addr  = 3'd1;
      nchk++;
      if (req_ready !== 1'b1) begin
         nfail++;
         $display("FAIL hs_ready_back: got %b want 1", req_ready);
      end
      exp_q.push_back(ref_mem[1]);
      last_rd = ref_mem[1];
      @(negedge clk);
      req_valid = 1'b0;
      nchk++;
      if (busy !== 1'b1 || mem_op !== 1'b0 || mem_address !== 3'd1) begin
         nfail++;
         $display("FAIL hs_second_accept: got busy=%b op=%b a=%h want 1/0/1",
                  busy, mem_op, mem_address);
      end
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      nchk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e) begin
         nfail++;
         $display("FAIL hs_rd_rsp: got v=%b rd=%h want 1/%h",
                  rsp_valid, rsp_rdata, e);
      end
   endtask

   task automatic test_reset_strobe();
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_clear = 1'b0;
      req_addr  = 3'd2;
      req_wdata = 8'h77;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      nchk++;
      if (mem_select !== 1'b1) begin
         nfail++;
         $display("FAIL rst_in_strobe: got sel=%b want 1", mem_select);
      end
      rst = 1'b1;
      @(negedge clk);
      nchk++;
      if (mem_select !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
          req_ready !== 1'b0) begin
         nfail++;
         $display("FAIL rst_abort: got sel=%b busy=%b v=%b rdy=%b want 0",
                  mem_select, busy, rsp_valid, req_ready);
      end
      rst = 1'b0;
      last_rd = 8'h00;
      @(negedge clk);
      nchk++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         nfail++;
         $display("FAIL rst_recover: got rdy=%b v=%b want 1/0",
                  req_ready, rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] a;
      for (int i = 0; i < 8; i++)
         one_access("b2b_wr", 1'b1, 3'(i), 8'($urandom));
      for (int i = 0; i < 8; i++) begin
         a = 3'($urandom);
         one_access("b2b_rd", 1'b0, a, 8'h00);
      end
   endtask

   task automatic test_clear();
      int         lat;
      int         nsel;
      bit         st;
      logic [7:0] e;
      bit         seq_ok;
      one_access("wrFF_a7", 1'b1, 3'd7, 8'hFF);
      if (CLR) begin
         issue(1'b0, 1'b1, 3'd5, 8'h5A, lat, nsel, st);
         nchk++;
         if (lat !== 23 || nsel !== 8) begin
            nfail++;
            $display("FAIL clr_len: got lat=%0d sel=%0d want 23/8", lat, nsel);
         end
         seq_ok = (sel_log.size() == 8);
         for (int i = 0; i < sel_log.size() && i < 8; i++)
            if (sel_log[i] !== 3'(i)) seq_ok = 1'b0;
         nchk++;
         if (!seq_ok) begin
            nfail++;
            $display("FAIL clr_addr_seq: got %0d strobes in wrong order, want 0..7",
                     sel_log.size());
         end
         e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
         nchk++;
         if (rsp_rdata !== e || st !== 1'b1) begin
            nfail++;
            $display("FAIL clr_rsp: got rd=%h stable=%0b want %h/1",
                     rsp_rdata, st, e);
         end
         for (int i = 0; i < 8; i++)
            one_access("clr_rd", 1'b0, 3'(i), 8'h00);
      end else begin
         one_access("wr3C_a3", 1'b1, 3'd3, 8'h3C);
         issue(1'b0, 1'b1, 3'd3, 8'h00, lat, nsel, st);
         nchk++;
         if (lat !== 2 || nsel !== 1 || mem_op !== 1'b0 ||
             mem_address !== 3'd3) begin
            nfail++;
            $display("FAIL noclr_read: got lat=%0d sel=%0d op=%b a=%h want 2/1/0/3",
                     lat, nsel, mem_op, mem_address);
         end
         e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
         nchk++;
         if (rsp_rdata !== e) begin
            nfail++;
            $display("FAIL noclr_rdata: got %h want %h", rsp_rdata, e);
         end
      end
   endtask

   initial begin
      nchk = 0;
      nfail = 0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'hxx;
      test_reset();
      test_write_read();
      test_second_word();
      test_handshake();
      test_reset_strobe();
      test_back_to_back();
      test_clear();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
